// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Assembles start/data/stop serial frames (LSB first) from a registered serial
// line into parallel words. Each word is held in a one-entry output buffer
// released under a valid/ready handshake. Bad stop bits raise frame_err and
// words lost to a full buffer raise overrun; both are one-cycle pulses.

module serial_frame_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             stop_good, stop_bad;
    logic             buf_free;

    // The buffer can take a new word if it is empty or being drained this cycle.
    assign buf_free = !valid || ready;

    // Next-state, bit counter and shift register; everything holds without en.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_next = state;
        count_next = count;
        shift_next = shift_reg;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_next = DATA;
                        count_next = '0;
                    end
                end
                DATA: begin
                    shift_next = {din, shift_reg[WIDTH-1:1]};
                    // The WIDTH-th data strobe arrives with count = WIDTH-1; the
                    // counter is cleared rather than incremented so it never
                    // goes past WIDTH-1.
                    if (count == LAST_BIT) begin
                        state_next = STOP;
                        count_next = '0;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
                STOP: begin
                    // A 0 here is a bad stop bit, never a new start bit.
                    state_next = IDLE;
                    if (din) stop_good = 1'b1;
                    else     stop_bad  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame-assembly state registers; busy is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so all
        // registers see the pre-edge values of each other, like real flops.
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            shift_reg <= shift_next;
            busy      <= (state_next != IDLE);
        end
    end

    // Output buffer, handshake and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= stop_good && !buf_free;
            if (stop_good && buf_free) begin
                data  <= shift_reg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Directed bench for serial_frame_rx: words expected at the consumer are queued
// when their frame is sent and compared when the handshake takes them.

module tb_serial_frame_rx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             din;
    logic             en;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_err_cnt = 0;
    int overrun_cnt   = 0;

    logic [WIDTH-1:0] exp_q[$];

    serial_frame_rx #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .en        (en),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare each word as the consumer takes it, count pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(data), 32'hDEAD);
                end else begin
                    check("scoreboard_word", 32'(data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) frame_err_cnt++;
            if (overrun)   overrun_cnt++;
            if (frame_err && overrun) check("err_exclusive", 32'd1, 32'd0);
        end
    end

    // One bit on the line, strobed once, then sp-1 idle (en=0) cycles.
    task automatic drive_bit(input logic b, input int sp);
        din = b;
        en  = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        repeat (sp - 1) begin
            @(posedge clk); #1;
        end
    endtask

    // Start bit plus WIDTH data bits, LSB first.
    task automatic send_bits(input logic [WIDTH-1:0] w, input int sp);
        drive_bit(1'b0, sp);
        for (int i = 0; i < WIDTH; i++) drive_bit(w[i], sp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},      32'(data),      32'h0);
        check({tag, "_valid"},     32'(valid),     32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_overrun"},   32'(overrun),   32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b1;
        en    = 1'b0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good frame 0x4A, dense strobe, 1-clock latency after the stop strobe.
        exp_q.push_back(8'h4A);
        send_bits(8'h4A, 1);
        check("t2_busy_in_stop", 32'(busy), 32'h1);
        drive_bit(1'b1, 1);
        check("t2_valid", 32'(valid), 32'h1);
        check("t2_data",  32'(data),  32'h4A);
        check("t2_busy",  32'(busy),  32'h0);
        ready = 1'b1;
        @(posedge clk); #1;
        check("t2_valid_drop", 32'(valid), 32'h0);
        check("t2_data_hold",  32'(data),  32'h4A);
        ready = 1'b0;

        // Framing error: 0xFF with a 0 stop bit.
        send_bits(8'hFF, 1);
        drive_bit(1'b0, 1);
        check("t3_frame_err", 32'(frame_err), 32'h1);
        check("t3_valid",     32'(valid),     32'h0);
        check("t3_busy",      32'(busy),      32'h0);
        din = 1'b1;
        @(posedge clk); #1;
        check("t3_frame_err_clear", 32'(frame_err), 32'h0);
        check("t3_err_pulses",      32'(frame_err_cnt), 32'd1);

        // Overrun: 0x12 held with ready=0, then 0x34 arrives and is dropped.
        exp_q.push_back(8'h12);
        send_bits(8'h12, 1);
        drive_bit(1'b1, 1);
        check("t4_first_valid", 32'(valid), 32'h1);
        send_bits(8'h34, 1);
        drive_bit(1'b1, 1);
        check("t4_overrun",   32'(overrun),   32'h1);
        check("t4_frame_err", 32'(frame_err), 32'h0);
        check("t4_data",      32'(data),      32'h12);
        check("t4_valid",     32'(valid),     32'h1);
        @(posedge clk); #1;
        check("t4_overrun_clear", 32'(overrun), 32'h0);
        check("t4_data_stable",   32'(data),    32'h12);
        ready = 1'b1;
        @(posedge clk); #1;
        check("t4_valid_drop", 32'(valid), 32'h0);
        ready = 1'b0;
        check("t4_ovr_pulses", 32'(overrun_cnt), 32'd1);

        // Drain and delivery on the same edge: 0x12 taken while 0x34 lands.
        exp_q.push_back(8'h12);
        send_bits(8'h12, 1);
        drive_bit(1'b1, 1);
        send_bits(8'h34, 1);
        exp_q.push_back(8'h34);
        ready = 1'b1;
        drive_bit(1'b1, 1);
        check("t5_valid",   32'(valid),   32'h1);
        check("t5_data",    32'(data),    32'h34);
        check("t5_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        check("t5_valid_drop", 32'(valid), 32'h0);
        ready = 1'b0;
        check("t5_ovr_pulses", 32'(overrun_cnt), 32'd1);

        // Sparse strobe: en every 4th cycle, frame 0xA5 left in the buffer.
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 4);
        check("t6_busy_hold",  32'(busy),  32'h1);
        check("t6_valid_wait", 32'(valid), 32'h0);
        drive_bit(1'b1, 4);
        check("t6_valid", 32'(valid), 32'h1);
        check("t6_data",  32'(data),  32'hA5);
        check("t6_busy",  32'(busy),  32'h0);

        // Async reset mid-DATA with a word still buffered.
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 1);
        drive_bit(1'b0, 1);
        check("t1_busy_before", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t1_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        din   = 1'b1;
        en    = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        en = 1'b0;
        check("t1_idle_busy",  32'(busy),  32'h0);
        check("t1_idle_valid", 32'(valid), 32'h0);

        // Normal operation after reset.
        exp_q.push_back(8'h5C);
        send_bits(8'h5C, 1);
        drive_bit(1'b1, 1);
        check("post_valid", 32'(valid), 32'h1);
        check("post_data",  32'(data),  32'h5C);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        check("post_valid_drop", 32'(valid), 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("err_pulses_final", 32'(frame_err_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
